// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline stall/flush/redirect controller with multicycle-unit
//            sequencing and deferred exception redirect.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int          NSTAGE   = 5,
    parameter int          NMC      = 2,
    parameter int          LOAD_LAT = 1,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              ex_rmem,
    input  logic [4:0]        ex_rt,
    input  logic              mem_rmem,
    input  logic [4:0]        mem_rt,
    input  logic [NMC-1:0]    mc_req,
    input  logic [NMC-1:0]    mc_ready,
    output logic [NMC-1:0]    mc_start,
    output logic              mc_abort,
    input  logic              stallreq_if,
    input  logic              stallreq_mem,
    input  logic              id_branch_stall,
    input  logic [31:0]       mem_excepttype,
    input  logic [31:0]       mem_cp0_epc,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              mc_busy
);

    localparam int          c_sel_w     = (NMC > 1) ? $clog2(NMC) : 1;
    localparam logic [31:0] c_eret_code = 32'h0000000E;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mc_state_t;

    mc_state_t          state_q;
    logic [c_sel_w-1:0] sel_q;
    logic               pend_q;
    logic [31:0]        pend_pc_q;

    logic               w_lu_ex;
    logic               w_lu_mem;
    logic               w_lu;
    logic               w_exc;
    logic               w_release;
    logic               w_exc_now;
    logic               w_flush_all;
    logic               w_mc_hold;
    logic               w_start_ok;
    logic               w_stall_front;
    logic               w_stall_back;
    logic [31:0]        w_exc_pc;
    logic [NMC-1:0]     w_start_oh;
    logic [c_sel_w-1:0] w_start_idx;

    assign w_lu_ex  = ex_rmem && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign w_lu_mem = (LOAD_LAT == 2) && mem_rmem && (mem_rt != 5'd0) &&
                      ((mem_rt == id_rs) || (mem_rt == id_rt));
    assign w_lu     = w_lu_ex || w_lu_mem;

    assign w_exc       = |mem_excepttype;
    assign w_exc_pc    = (mem_excepttype == c_eret_code) ? mem_cp0_epc : EXC_VEC;
    // A latched exception owns the redirect; newer ones are dropped until it retires.
    assign w_release   = pend_q && !stallreq_mem;
    assign w_exc_now   = w_exc && !stallreq_mem && !pend_q;
    assign w_flush_all = !rst && (w_release || w_exc_now);

    always_comb begin
        w_start_oh  = '0;
        w_start_idx = '0;
        for (int i = NMC - 1; i >= 0; i--) begin
            if (mc_req[i]) begin
                w_start_oh    = '0;
                w_start_oh[i] = 1'b1;
                w_start_idx   = c_sel_w'(i);
            end
        end
    end

    assign w_start_ok    = !rst && (state_q == S_IDLE) && (|mc_req) && !w_exc && !pend_q;
    assign w_mc_hold     = ((state_q == S_IDLE) && (|mc_req)) || (state_q == S_WAIT);
    assign w_stall_front = w_lu || id_branch_stall || stallreq_if || w_mc_hold || stallreq_mem;
    assign w_stall_back  = w_mc_hold || stallreq_mem;

    always_comb begin
        stall = '0;
        flush = '0;
        if (!rst) begin
            if (w_flush_all) begin
                flush = '1;
            end else begin
                flush[2]   = w_lu;
                flush[4]   = stallreq_mem;
                stall[1:0] = {2{w_stall_front}};
                stall[3:2] = {2{w_stall_back}};
                stall      = stall & ~flush;
            end
        end
    end

    assign mc_start       = w_start_ok ? w_start_oh : '0;
    assign mc_abort       = w_flush_all && (state_q != S_IDLE);
    assign mc_busy        = (state_q != S_IDLE);
    assign redirect_valid = w_flush_all;
    assign redirect_pc    = w_flush_all ? (pend_q ? pend_pc_q : w_exc_pc) : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
        end else begin
            if (w_release) begin
                pend_q <= 1'b0;
            end else if (!pend_q && w_exc && stallreq_mem) begin
                pend_q    <= 1'b1;
                pend_pc_q <= w_exc_pc;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_start_ok) begin
                        sel_q   <= w_start_idx;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_flush_all)
                        state_q <= S_IDLE;
                    else if (mc_ready[sel_q])
                        state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed and randomized checks of pipe_hazard_ctrl against a
//            behavioural model.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt, mem_rt;
    logic        ex_rmem, mem_rmem;
    logic [1:0]  mc_req, mc_ready;
    logic        stallreq_if, stallreq_mem, id_branch_stall;
    logic [31:0] mem_excepttype, mem_cp0_epc;

    logic [1:0]  mc_start_a, mc_start_b;
    logic        mc_abort_a, mc_abort_b, rv_a, rv_b, busy_a, busy_b;
    logic [4:0]  stall_a, flush_a, stall_b, flush_b;
    logic [31:0] rpc_a, rpc_b;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit          m_waiting, m_justdone, m_pend;
    int          m_unit;
    logic [31:0] m_pc;
    int          srm_left = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rmem(ex_rmem), .ex_rt(ex_rt), .mem_rmem(mem_rmem), .mem_rt(mem_rt),
        .mc_req(mc_req), .mc_ready(mc_ready), .mc_start(mc_start_a), .mc_abort(mc_abort_a),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .id_branch_stall(id_branch_stall),
        .mem_excepttype(mem_excepttype), .mem_cp0_epc(mem_cp0_epc),
        .stall(stall_a), .flush(flush_a), .redirect_valid(rv_a), .redirect_pc(rpc_a),
        .mc_busy(busy_a)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(2)) u_dut_ll2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rmem(ex_rmem), .ex_rt(ex_rt), .mem_rmem(mem_rmem), .mem_rt(mem_rt),
        .mc_req(mc_req), .mc_ready(mc_ready), .mc_start(mc_start_b), .mc_abort(mc_abort_b),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .id_branch_stall(id_branch_stall),
        .mem_excepttype(mem_excepttype), .mem_cp0_epc(mem_cp0_epc),
        .stall(stall_b), .flush(flush_b), .redirect_valid(rv_b), .redirect_pc(rpc_b),
        .mc_busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waiting  = 1'b0;
        m_justdone = 1'b0;
        m_pend     = 1'b0;
        m_unit     = 0;
        m_pc       = 32'h0;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0; mem_rt = 0;
        ex_rmem = 0; mem_rmem = 0; mc_req = 0; mc_ready = 0;
        stallreq_if = 0; stallreq_mem = 0; id_branch_stall = 0;
        mem_excepttype = 0; mem_cp0_epc = 0;
    endtask

    function automatic logic [9:0] exp_sf(input bit lu, input bit hold, input bit fl_all);
        logic [4:0] st, fl;
        st = 5'b0;
        fl = 5'b0;
        if (lu || id_branch_stall || stallreq_if || hold || stallreq_mem) st |= 5'b00011;
        if (hold || stallreq_mem) st |= 5'b01100;
        if (lu) fl |= 5'b00100;
        if (stallreq_mem) fl |= 5'b10000;
        if (fl_all) fl = 5'b11111;
        st &= ~fl;
        return {st, fl};
    endfunction

    // Entered just after a rising edge; compares at the falling edge,
    // advances the model, and returns just after the next rising edge.
    task automatic check_cycle();
        bit          lu1, lu2, exc, rel, now, fl_all, busy, hold;
        logic [1:0]  start;
        logic [9:0]  sf1, sf2;
        logic [31:0] pcsel, rpc;
        @(negedge clk);
        if (rst) begin
            chk("rst_stall", {27'b0, stall_a}, 32'h0);
            chk("rst_flush", {27'b0, flush_a}, 32'h0);
            chk("rst_start", {30'b0, mc_start_a}, 32'h0);
            chk("rst_abort", {31'b0, mc_abort_a}, 32'h0);
            chk("rst_busy", {31'b0, busy_a}, 32'h0);
            chk("rst_rv", {31'b0, rv_a}, 32'h0);
            chk("rst_rpc", rpc_a, 32'h0);
            chk("rst_stall_ll2", {27'b0, stall_b}, 32'h0);
            model_reset();
        end else begin
            lu1 = ex_rmem && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
            lu2 = lu1 || (mem_rmem && mem_rt != 0 && (mem_rt == id_rs || mem_rt == id_rt));
            exc    = (mem_excepttype != 0);
            pcsel  = (mem_excepttype == 32'hE) ? mem_cp0_epc : 32'hBFC00380;
            rel    = m_pend && !stallreq_mem;
            now    = exc && !stallreq_mem && !m_pend;
            fl_all = rel || now;
            busy   = m_waiting || m_justdone;
            hold   = m_waiting || (!busy && mc_req != 0);
            start  = (!busy && mc_req != 0 && !exc && !m_pend) ? (mc_req & (~mc_req + 2'd1)) : 2'b00;
            rpc    = fl_all ? (rel ? m_pc : pcsel) : 32'h0;
            sf1    = exp_sf(lu1, hold, fl_all);
            sf2    = exp_sf(lu2, hold, fl_all);

            chk("stall", {27'b0, stall_a}, {27'b0, sf1[9:5]});
            chk("flush", {27'b0, flush_a}, {27'b0, sf1[4:0]});
            chk("stall_ll2", {27'b0, stall_b}, {27'b0, sf2[9:5]});
            chk("flush_ll2", {27'b0, flush_b}, {27'b0, sf2[4:0]});
            chk("redirect_valid", {31'b0, rv_a}, {31'b0, fl_all});
            chk("redirect_pc", rpc_a, rpc);
            chk("mc_start", {30'b0, mc_start_a}, {30'b0, start});
            chk("mc_abort", {31'b0, mc_abort_a}, {31'b0, fl_all && busy});
            chk("mc_busy", {31'b0, busy_a}, {31'b0, busy});

            if (fl_all && busy) begin
                m_waiting  = 1'b0;
                m_justdone = 1'b0;
            end else if (m_waiting) begin
                if (mc_ready[m_unit]) begin
                    m_waiting  = 1'b0;
                    m_justdone = 1'b1;
                end
            end else if (m_justdone) begin
                m_justdone = 1'b0;
            end else if (start != 0) begin
                m_waiting = 1'b1;
                m_unit    = start[0] ? 0 : 1;
            end

            if (rel) begin
                m_pend = 1'b0;
            end else if (!m_pend && exc && stallreq_mem) begin
                m_pend = 1'b1;
                m_pc   = pcsel;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic random_inputs();
        int r;
        id_rs    = 5'($urandom_range(0, 3));
        id_rt    = 5'($urandom_range(0, 3));
        ex_rt    = 5'($urandom_range(0, 3));
        mem_rt   = 5'($urandom_range(0, 3));
        ex_rmem  = ($urandom_range(0, 2) == 0);
        mem_rmem = ($urandom_range(0, 2) == 0);
        id_branch_stall = ($urandom_range(0, 7) == 0);
        stallreq_if     = ($urandom_range(0, 7) == 0);
        if (srm_left > 0) begin
            stallreq_mem = 1'b1;
            srm_left--;
        end else if ($urandom_range(0, 9) == 0) begin
            stallreq_mem = 1'b1;
            srm_left = $urandom_range(0, 4);
        end else begin
            stallreq_mem = 1'b0;
        end
        r = $urandom_range(0, 11);
        mem_excepttype = (r == 0) ? 32'h8 : (r == 1) ? 32'hE : (r == 2) ? ($urandom | 32'h1) : 32'h0;
        mem_cp0_epc    = $urandom;
        mc_req   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        mc_ready = 2'($urandom_range(0, 3));
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Outputs must stay quiet under reset even with hazard sources active.
        ex_rmem = 1; ex_rt = 5; id_rs = 5; mc_req = 2'b01; mem_excepttype = 32'h8;
        check_cycle();
        rst = 1'b0;
        clear_inputs();
        check_cycle();

        // Load-use in EX, then r0 destination
        ex_rmem = 1; ex_rt = 5; id_rs = 5;
        check_cycle();
        ex_rt = 0;
        check_cycle();
        clear_inputs();

        // Load-use in MEM only matters with LOAD_LAT=2
        mem_rmem = 1; mem_rt = 7; id_rt = 7;
        check_cycle();
        clear_inputs();

        // Multicycle sequence: start lowest, ignore other ready bit
        mc_req = 2'b11;
        check_cycle();
        mc_ready = 2'b10;
        repeat (3) check_cycle();
        mc_ready = 2'b01;
        check_cycle();
        mc_ready = 2'b00;
        check_cycle();
        mc_req = 2'b00;
        check_cycle();

        // Immediate exceptions
        mem_excepttype = 32'h8;
        check_cycle();
        mem_excepttype = 32'hE; mem_cp0_epc = 32'h8000_1234;
        check_cycle();
        clear_inputs();

        // Deferred exception with a second one ignored while held
        mem_excepttype = 32'h8; stallreq_mem = 1;
        check_cycle();
        mem_excepttype = 32'h0;
        check_cycle();
        mem_excepttype = 32'hE; mem_cp0_epc = 32'h1111_2222;
        check_cycle();
        mem_excepttype = 32'h0;
        check_cycle();
        stallreq_mem = 0;
        check_cycle();
        check_cycle();

        // Exception while waiting on a multicycle unit
        mc_req = 2'b01;
        check_cycle();
        check_cycle();
        mem_excepttype = 32'h8;
        check_cycle();
        clear_inputs();
        check_cycle();

        // Asynchronous reset in the middle of a wait
        mc_req = 2'b10;
        check_cycle();
        check_cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'b0, busy_a}, 32'h0);
        chk("async_rst_abort", {31'b0, mc_abort_a}, 32'h0);
        chk("async_rst_stall", {27'b0, stall_a}, 32'h0);
        model_reset();
        check_cycle();
        rst = 1'b0;
        clear_inputs();
        check_cycle();

        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            check_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
